// File: rtl/irq_pkg.sv
// Shared types and helpers for the external interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    FIN     = 2'd3
  } irq_state_e;

  localparam int unsigned IRQ_CAUSE_BASE = 16;
  localparam int unsigned MCAUSE_INT_BIT = 31;

  // Platform line idx reports cause code 16+idx with the interrupt flag set.
  function automatic logic [31:0] irq_mcause(logic [31:0] idx);
    return (32'd1 << MCAUSE_INT_BIT) | (idx + 32'(IRQ_CAUSE_BASE));
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Device/core-side signal bundle of the interrupt controller.
interface irq_controller_if #(
  parameter int unsigned N_IRQ = 16
);
  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             stall_i;
  logic             mret_i;
  logic             irq_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] irq_ack_o;
  logic             busy_o;

  modport slave (
    input  irq_req_i, mie_i, stall_i, mret_i,
    output irq_o, mcause_o, irq_ack_o, busy_o
  );

  modport master (
    output irq_req_i, mie_i, stall_i, mret_i,
    input  irq_o, mcause_o, irq_ack_o, busy_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the masked request lines.
module irq_prio_enc #(
  parameter int unsigned N_IRQ = 16,
  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Sequences one external interrupt at a time into the core trap path:
// arbitrate, request the trap, wait for mret, then acknowledge the device.
//
// state   | meaning
// IDLE    | arbitrating masked requests every cycle
// REQ     | irq_o high, waiting for an unstalled cycle to take the trap
// SERVICE | handler running, waiting for mret
// FIN     | one-cycle ack pulse to the serviced device
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ = 16,
  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  irq_controller_if.slave  bus
);

  irq_state_e       state_q, state_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic [31:0]      mcause_q, mcause_d;
  logic             irq_q, irq_d;
  logic [N_IRQ-1:0] ack_q, ack_d;

  logic [N_IRQ-1:0] masked;
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;

  // mie bits outside the platform range have no meaning here.
  logic unused_mie;
  assign unused_mie = ^bus.mie_i;

  assign masked = bus.irq_req_i & bus.mie_i[IRQ_CAUSE_BASE +: N_IRQ];

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .req_i   (masked),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  // Next-state logic; inputs only matter in IDLE (arbitration), REQ (stall)
  // and SERVICE (mret), so a committed interrupt cannot be withdrawn.
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    mcause_d = mcause_q;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d  = REQ;
          id_d     = sel_idx;
          mcause_d = irq_mcause(32'(sel_idx));
        end
      end
      REQ:     if (!bus.stall_i) state_d = SERVICE;
      SERVICE: if (bus.mret_i)   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
    ack_d = (state_d == FIN) ? (N_IRQ'(1) << id_d) : '0;
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= '0;
      mcause_q <= '0;
      irq_q    <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      mcause_q <= mcause_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.irq_o     = irq_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.irq_ack_o = ack_q;
  assign bus.busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk_i = ~clk_i;

  irq_controller_if #(.N_IRQ(16)) bus ();

  irq_controller #(.N_IRQ(16)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic outs(input string tag, input logic irq, input logic busy,
                      input logic [15:0] ack, input logic [31:0] mc);
    chk({tag, ".irq"},    32'(bus.irq_o),     32'(irq));
    chk({tag, ".busy"},   32'(bus.busy_o),    32'(busy));
    chk({tag, ".ack"},    32'(bus.irq_ack_o), 32'(ack));
    chk({tag, ".mcause"}, bus.mcause_o,       mc);
  endtask

  task automatic mret_pulse();
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
  endtask

  initial begin
    bus.irq_req_i = '0;
    bus.mie_i     = '0;
    bus.stall_i   = 1'b0;
    bus.mret_i    = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    outs("reset", 0, 0, 16'h0000, 32'h0);

    // Single line 3
    bus.mie_i = 32'h0008_0000;
    bus.irq_req_i = 16'h0008;
    tick();
    outs("single_req", 1, 1, 16'h0000, 32'h8000_0013);
    tick();
    outs("single_svc", 0, 1, 16'h0000, 32'h8000_0013);
    tick();
    tick();
    outs("single_wait", 0, 1, 16'h0000, 32'h8000_0013);
    mret_pulse();
    outs("single_fin", 0, 1, 16'h0008, 32'h8000_0013);
    bus.irq_req_i = '0;
    tick();
    outs("single_idle", 0, 0, 16'h0000, 32'h8000_0013);

    // Spurious mret in IDLE
    mret_pulse();
    outs("mret_idle", 0, 0, 16'h0000, 32'h8000_0013);

    // Priority: lines 2 and 5
    bus.mie_i = 32'h0024_0000;
    bus.irq_req_i = 16'h0024;
    tick();
    outs("prio_req2", 1, 1, 16'h0000, 32'h8000_0012);
    tick();
    mret_pulse();
    outs("prio_fin2", 0, 1, 16'h0004, 32'h8000_0012);
    bus.irq_req_i = 16'h0020;
    tick();
    outs("prio_idle", 0, 0, 16'h0000, 32'h8000_0012);
    tick();
    outs("prio_req5", 1, 1, 16'h0000, 32'h8000_0015);
    tick();
    mret_pulse();
    outs("prio_fin5", 0, 1, 16'h0020, 32'h8000_0015);
    bus.irq_req_i = '0;
    tick();

    // Masking: line 7 pending with its enable clear
    bus.mie_i = 32'hFF7F_FFFF;
    bus.irq_req_i = 16'h0080;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mask_hold.irq", 32'(bus.irq_o), 32'd0);
    end
    bus.mie_i = 32'h0080_0000;
    tick();
    outs("mask_open", 1, 1, 16'h0000, 32'h8000_0017);
    tick();
    mret_pulse();
    outs("mask_fin", 0, 1, 16'h0080, 32'h8000_0017);
    bus.irq_req_i = '0;
    tick();

    // Stall: three stalled REQ cycles then one unstalled
    bus.mie_i = 32'h0002_0000;
    bus.irq_req_i = 16'h0002;
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("stall_req", 1, 1, 16'h0000, 32'h8000_0011);
    end
    tick();
    outs("stall_last", 1, 1, 16'h0000, 32'h8000_0011);
    bus.stall_i = 1'b0;
    tick();
    outs("stall_svc", 0, 1, 16'h0000, 32'h8000_0011);
    mret_pulse();
    outs("stall_fin", 0, 1, 16'h0002, 32'h8000_0011);
    bus.irq_req_i = '0;
    tick();

    // Commitment: mret ignored in REQ, request dropped before the trap is taken
    bus.mie_i = 32'h0001_0000;
    bus.irq_req_i = 16'h0001;
    tick();
    bus.stall_i = 1'b1;
    bus.mret_i = 1'b1;
    tick();
    bus.mret_i = 1'b0;
    outs("commit_req", 1, 1, 16'h0000, 32'h8000_0010);
    bus.irq_req_i = '0;
    bus.mie_i = '0;
    bus.stall_i = 1'b0;
    tick();
    outs("commit_svc", 0, 1, 16'h0000, 32'h8000_0010);
    mret_pulse();
    outs("commit_fin", 0, 1, 16'h0001, 32'h8000_0010);
    tick();
    outs("commit_idle", 0, 0, 16'h0000, 32'h8000_0010);

    // Asynchronous reset mid-SERVICE on line 3
    bus.mie_i = 32'h0008_0000;
    bus.irq_req_i = 16'h0008;
    tick();
    tick();
    outs("rst_svc", 0, 1, 16'h0000, 32'h8000_0013);
    #1;
    rst_i = 1'b1;
    #1;
    outs("rst_async", 0, 0, 16'h0000, 32'h0);
    bus.irq_req_i = '0;
    tick();
    rst_i = 1'b0;
    mret_pulse();
    for (int i = 0; i < 4; i++) begin
      tick();
      outs("rst_noack", 0, 0, 16'h0000, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Sequences external interrupt delivery into the core's trap path and CSR file.
- Masks platform interrupt lines with mie, picks one by fixed priority and raises a single trap request to the core.
- Drives the mcause value the CSR file captures on trap entry, waits for mret, then acknowledges the serviced device.
- No nesting: one interrupt in flight at a time.

Parameters:
- N_IRQ, 16, number of platform interrupt lines (1..16); line i maps to mie bit 16+i and cause code 16+i.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- irq_req_i  input  N_IRQ  level interrupt requests from devices
- mie_i  input  32  current mie CSR value
- stall_i  input  1  core pipeline stalled; trap cannot be taken this cycle
- mret_i  input  1  core is executing mret this cycle (single-cycle pulse)
- irq_o  output  1  trap request to core (drives CSR trap-write path)
- mcause_o  output  32  cause for CSR mcause capture
- irq_ack_o  output  N_IRQ  one-hot, one-cycle completion acknowledge to the device
- busy_o  output  1  an interrupt is in flight (state != IDLE)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, id_q=0, irq_o=0, mcause_o=0, irq_ack_o=0, busy_o=0.
- masked = irq_req_i & mie_i[16 +: N_IRQ], combinational. Selection: lowest set index wins.
- States are IDLE, REQ, SERVICE and FIN.
- IDLE:
  - If |masked at edge t, latch id_q=lowest index, mcause_q=32'h8000_0000 | (16+id_q), then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - irq_o=1 (registered; first high in the cycle after the request is sampled, i.e. one-cycle latency).
  - The core takes the trap in the first REQ cycle with stall_i=0 and writes mepc/mcause that cycle.
  - On a REQ cycle with stall_i=0, go to SERVICE; while stall_i=1, hold REQ with irq_o=1.
- SERVICE: irq_o=0. On mret_i=1, go to FIN.
- FIN:
  - irq_ack_o[id_q]=1 for exactly one cycle, then go to IDLE.
  - Arbitration resumes in the following IDLE cycle on current inputs.
  - Minimum IDLE-to-IDLE turnaround is 4 cycles with no stall.
- mcause_o: holds mcause_q from REQ entry through FIN and keeps its last value in IDLE. It changes only on an IDLE to REQ transition.
- Commitment: once REQ is entered, the interrupt is delivered even if its request drops or mie changes. Request and mask changes in REQ, SERVICE and FIN are ignored.
- mret_i in IDLE, REQ or FIN is ignored, with no state change.
- Simultaneous requests: the lowest index is served. Remaining lines stay pending at the device (level) and are re-arbitrated after FIN.
- Fairness: no starvation guarantee beyond fixed priority, by design.
- A request that asserts and deasserts entirely while not in IDLE is lost; devices must hold the level until irq_ack_o.
- busy_o = (state != IDLE).
- irq_ack_o is all-zero outside FIN.
- N_IRQ<16: unused mie bits are ignored.

Decomposition:
- Package irq_pkg:
  - irq_state_e enum (IDLE, REQ, SERVICE, FIN)
  - IRQ_CAUSE_BASE = 16
  - MCAUSE_INT_BIT = 31
  - function building mcause from an index
- Sub-module irq_prio_enc: parameterised lowest-index priority encoder producing valid and a $clog2(N_IRQ)-bit index. It is purely combinational and instantiated once.

Test Plan:
- Reset:
  - Assert rst_i mid-SERVICE (id=3) -> irq_o=0, busy_o=0 and mcause_o=0 immediately (asynchronous).
  - No irq_ack_o pulse follows after release.
- Single line:
  - mie_i=32'h0008_0000, irq_req_i[3]=1 at cycle t -> irq_o=1 at t+1 and mcause_o=32'h8000_0013.
  - SERVICE at t+2; mret_i at t+5 -> irq_ack_o=16'h0008 at t+6 for one cycle, then IDLE.
- Priority:
  - irq_req_i=16'h0024 with both enabled -> line 2 served first (mcause 0x80000012).
  - After ack, with line 5 still high -> mcause 0x80000015.
- Masking: irq_req_i[7]=1, mie_i bit 23=0 -> irq_o stays 0 for 20 cycles. Setting bit 23 -> irq_o=1 on the next cycle.
- Stall: stall_i=1 for 3 cycles during REQ -> irq_o held 1 for 4 cycles, mcause_o stable; SERVICE entered after the first unstalled cycle.
- Spurious/commit:
  - mret_i pulsed in IDLE -> no state change.
  - irq_req_i dropped during REQ -> trap still delivered and acked.
